// File: rtl/sys_ctrl_burst_pkg.sv
// sys_ctrl_pkg: shared opcodes, FSM state encoding and sizing helpers
// for the burst-capable system controller.
package sys_ctrl_pkg;

  localparam logic [7:0] OP_WR     = 8'hAA;
  localparam logic [7:0] OP_RD     = 8'hBB;
  localparam logic [7:0] OP_ALU_OP = 8'hCC;
  localparam logic [7:0] OP_ALU    = 8'hDD;
  localparam logic [7:0] OP_BWR    = 8'hEE;
  localparam logic [7:0] OP_BRD    = 8'hEF;

  typedef enum logic [3:0] {
    IDLE,
    GET_ADDR,
    GET_CNT,
    GET_DATA,
    RF_WR,
    RF_RD,
    RD_WAIT,
    GET_A,
    GET_B,
    GET_FUN,
    ALU_RUN,
    ALU_WAIT,
    TX_SEND
  } state_t;

  function automatic int out_bytes(
    input int w,
    input int d
  );
    return (w + d - 1) / d;
  endfunction

  function automatic logic is_get(
    input state_t s
  );
    return s inside {GET_ADDR, GET_CNT,
                     GET_DATA, GET_A,
                     GET_B, GET_FUN};
  endfunction

endpackage

// File: rtl/sys_ctrl_burst_tx_byte_ser.sv
// tx_byte_ser: shifts a loaded word out LSB byte first, one byte per
// cycle, stalling with the current byte held while the FIFO is full.
module tx_byte_ser #(
  parameter int DW = 8,
  parameter int NB = 2,
  parameter int CW = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [NB*DW-1:0] word,
  input  logic [CW-1:0]   nbytes,
  input  logic            full,
  output logic [DW-1:0]   data,
  output logic            vld,
  output logic            last
);

  logic [NB*DW-1:0] sh_q;
  logic [CW-1:0]    left_q;

  assign vld  = (left_q != '0) && !full;
  assign last = vld && (left_q == CW'(1));
  assign data = sh_q[DW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q   <= '0;
      left_q <= '0;
    end else if (load) begin
      sh_q   <= word;
      left_q <= nbytes;
    end else if (vld) begin
      sh_q   <= sh_q >> DW;
      left_q <= left_q - 1'b1;
    end
  end

endmodule

// File: rtl/sys_ctrl_burst.sv
// sys_ctrl_burst: UART command decoder driving RF, ALU and TX FIFO.
// Optional inter-byte timeout abort: define CMD_TIMEOUT_EN.
import sys_ctrl_pkg::*;

module sys_ctrl_burst #(
  parameter int DATA_WIDTH  = 8,
  parameter int RF_ADDR     = 4,
  parameter int ALU_FUN_W   = 4,
  parameter int ALU_OUT_W   = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] UART_RX_DATA,
  input  logic                  UART_RX_VLD,
  input  logic [DATA_WIDTH-1:0] RF_RdData,
  input  logic                  RF_RdData_VLD,
  input  logic [ALU_OUT_W-1:0]  ALU_OUT,
  input  logic                  ALU_OUT_VLD,
  input  logic                  FIFO_FULL,
  output logic                  RF_WrEn,
  output logic                  RF_RdEn,
  output logic [RF_ADDR-1:0]    RF_Address,
  output logic [DATA_WIDTH-1:0] RF_WrData,
  output logic                  ALU_EN,
  output logic [ALU_FUN_W-1:0]  ALU_FUN,
  output logic                  CLKG_EN,
  output logic                  CLKDIV_EN,
  output logic [DATA_WIDTH-1:0] UART_TX_DATA,
  output logic                  UART_TX_VLD,
  output logic                  CMD_ERR
);

  localparam int OB = out_bytes(ALU_OUT_W, DATA_WIDTH);
  localparam int WW = OB * DATA_WIDTH;
  localparam int CW = $clog2(OB + 1);

  state_t                state_q, st_d;
  logic [7:0]            opc_q, opc_d;
  logic [RF_ADDR-1:0]    addr_q, addr_d;
  logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [ALU_FUN_W-1:0]  fun_q, fun_d;
  logic                  err_q, err_d;
  logic                  div_q;
  logic                  ld, ser_last, tmo;
  logic [WW-1:0]         ld_word;
  logic [CW-1:0]         ld_n;
  logic [7:0]            rx_b;

  assign rx_b       = UART_RX_DATA[7:0];
  assign RF_Address = addr_q;
  assign RF_WrData  = data_q;
  assign ALU_FUN    = ALU_EN ? fun_q : '0;
  assign CLKDIV_EN  = div_q;
  assign CMD_ERR    = err_q;

`ifdef CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      tmo_q <= '0;
    else if (!is_get(state_q) || UART_RX_VLD)
      tmo_q <= '0;
    else
      tmo_q <= tmo_q + 1'b1;
  end

  assign tmo = is_get(state_q) && !UART_RX_VLD &&
               (tmo_q == TW'(TIMEOUT_CYC - 1));
`else
  assign tmo = 1'b0 && (TIMEOUT_CYC > 0);
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      opc_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      fun_q   <= '0;
      err_q   <= 1'b0;
      div_q   <= 1'b0;
    end else begin
      state_q <= st_d;
      opc_q   <= opc_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      fun_q   <= fun_d;
      err_q   <= err_d;
      div_q   <= 1'b1;
    end
  end

  always_comb begin
    st_d    = state_q;
    opc_d   = opc_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    fun_d   = fun_q;
    err_d   = 1'b0;
    ld      = 1'b0;
    ld_word = '0;
    ld_n    = '0;
    RF_WrEn = 1'b0;
    RF_RdEn = 1'b0;
    ALU_EN  = 1'b0;
    CLKG_EN = 1'b0;
    unique case (state_q)
      IDLE: if (UART_RX_VLD) begin
        opc_d = rx_b;
        unique case (1'b1)
          (rx_b == OP_WR),
          (rx_b == OP_RD),
          (rx_b == OP_BWR),
          (rx_b == OP_BRD):    st_d = GET_ADDR;
          (rx_b == OP_ALU_OP): st_d = GET_A;
          (rx_b == OP_ALU):    st_d = GET_FUN;
          default:             err_d = 1'b1;
        endcase
      end
      GET_ADDR: if (UART_RX_VLD) begin
        addr_d = UART_RX_DATA[RF_ADDR-1:0];
        st_d   = (opc_q == OP_WR) ? GET_DATA :
                 (opc_q == OP_RD) ? RF_RD : GET_CNT;
      end
      GET_CNT: if (UART_RX_VLD) begin
        cnt_d = UART_RX_DATA;
        if (UART_RX_DATA == '0)
          st_d = IDLE;
        else
          st_d = (opc_q == OP_BWR) ? GET_DATA : RF_RD;
      end
      GET_DATA: if (UART_RX_VLD) begin
        data_d = UART_RX_DATA;
        st_d   = RF_WR;
      end
      GET_A: if (UART_RX_VLD) begin
        data_d = UART_RX_DATA;
        addr_d = '0;
        st_d   = RF_WR;
      end
      GET_B: if (UART_RX_VLD) begin
        data_d = UART_RX_DATA;
        addr_d = RF_ADDR'(1);
        st_d   = RF_WR;
      end
      RF_WR: begin
        RF_WrEn = 1'b1;
        unique case (1'b1)
          (opc_q == OP_ALU_OP):
            st_d = (addr_q == '0) ? GET_B : GET_FUN;
          (opc_q == OP_BWR): begin
            cnt_d  = cnt_q - 1'b1;
            addr_d = addr_q + 1'b1;
            st_d   = (cnt_q == DATA_WIDTH'(1)) ?
                     IDLE : GET_DATA;
          end
          default: st_d = IDLE;
        endcase
      end
      GET_FUN: if (UART_RX_VLD) begin
        fun_d = UART_RX_DATA[ALU_FUN_W-1:0];
        st_d  = ALU_RUN;
      end
      ALU_RUN: begin
        CLKG_EN = 1'b1;
        st_d    = ALU_WAIT;
      end
      ALU_WAIT: begin
        CLKG_EN = 1'b1;
        ALU_EN  = 1'b1;
        if (ALU_OUT_VLD) begin
          ld      = 1'b1;
          ld_word = WW'(ALU_OUT);
          ld_n    = CW'(OB);
          st_d    = TX_SEND;
        end
      end
      RF_RD: begin
        RF_RdEn = 1'b1;
        st_d    = RD_WAIT;
      end
      RD_WAIT: if (RF_RdData_VLD) begin
        ld      = 1'b1;
        ld_word = WW'(RF_RdData);
        ld_n    = CW'(1);
        st_d    = TX_SEND;
      end
      TX_SEND: if (ser_last) begin
        if (opc_q == OP_BRD &&
            cnt_q > DATA_WIDTH'(1)) begin
          cnt_d  = cnt_q - 1'b1;
          addr_d = addr_q + 1'b1;
          st_d   = RF_RD;
        end else begin
          st_d = IDLE;
        end
      end
      default: st_d = IDLE;
    endcase
    // abort leaves already committed burst writes in place
    if (tmo) begin
      st_d  = IDLE;
      err_d = 1'b1;
    end
  end

  tx_byte_ser #(
    .DW(DATA_WIDTH),
    .NB(OB),
    .CW(CW)
  ) u_ser (
    .clk   (CLK),
    .rst_n (RST),
    .load  (ld),
    .word  (ld_word),
    .nbytes(ld_n),
    .full  (FIFO_FULL),
    .data  (UART_TX_DATA),
    .vld   (UART_TX_VLD),
    .last  (ser_last)
  );

endmodule

// File: tb/tb_sys_ctrl_burst.sv
// tb_sys_ctrl_burst: directed bench with RF/ALU responders and
// strobe monitors; define CMD_TIMEOUT_EN to add the timeout test.
module tb_sys_ctrl_burst;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] UART_RX_DATA;
  logic       UART_RX_VLD;
  logic [7:0] RF_RdData;
  logic       RF_RdData_VLD;
  logic [15:0] ALU_OUT;
  logic       ALU_OUT_VLD;
  logic       FIFO_FULL;
  logic       RF_WrEn, RF_RdEn;
  logic [3:0] RF_Address;
  logic [7:0] RF_WrData;
  logic       ALU_EN;
  logic [3:0] ALU_FUN;
  logic       CLKG_EN, CLKDIV_EN;
  logic [7:0] UART_TX_DATA;
  logic       UART_TX_VLD;
  logic       CMD_ERR;

  int total = 0;
  int bad   = 0;

  sys_ctrl_burst dut (
    .CLK          (CLK),
    .RST          (RST),
    .UART_RX_DATA (UART_RX_DATA),
    .UART_RX_VLD  (UART_RX_VLD),
    .RF_RdData    (RF_RdData),
    .RF_RdData_VLD(RF_RdData_VLD),
    .ALU_OUT      (ALU_OUT),
    .ALU_OUT_VLD  (ALU_OUT_VLD),
    .FIFO_FULL    (FIFO_FULL),
    .RF_WrEn      (RF_WrEn),
    .RF_RdEn      (RF_RdEn),
    .RF_Address   (RF_Address),
    .RF_WrData    (RF_WrData),
    .ALU_EN       (ALU_EN),
    .ALU_FUN      (ALU_FUN),
    .CLKG_EN      (CLKG_EN),
    .CLKDIV_EN    (CLKDIV_EN),
    .UART_TX_DATA (UART_TX_DATA),
    .UART_TX_VLD  (UART_TX_VLD),
    .CMD_ERR      (CMD_ERR)
  );

  always #5 CLK = ~CLK;

  // RF model: reset image mem[i] = 0x10+i, read data 2 cycles after RdEn
  logic [7:0] mem [16];
  logic       p1;
  logic [3:0] a1;

  always @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'(16 + i);
      p1            <= 1'b0;
      a1            <= '0;
      RF_RdData     <= '0;
      RF_RdData_VLD <= 1'b0;
    end else begin
      if (RF_WrEn) mem[RF_Address] <= RF_WrData;
      p1            <= RF_RdEn;
      a1            <= RF_Address;
      RF_RdData_VLD <= p1;
      if (p1) RF_RdData <= mem[a1];
    end
  end

  // ALU model: result valid on the 3rd cycle of ALU_EN
  logic [15:0] alu_val;
  int          acnt;

  always @(posedge CLK) begin
    if (!RST || !ALU_EN || ALU_OUT_VLD) begin
      acnt        <= 0;
      ALU_OUT_VLD <= 1'b0;
      ALU_OUT     <= '0;
    end else begin
      acnt <= acnt + 1;
      if (acnt == 1) begin
        ALU_OUT_VLD <= 1'b1;
        ALU_OUT     <= alu_val;
      end
    end
  end

  logic [3:0] wr_a[$];
  logic [7:0] wr_d[$];
  logic [3:0] rd_q[$];
  logic [7:0] tx_q[$];
  int         err_cnt, viol, en_cyc;
  logic [3:0] fun_log;

  always @(negedge CLK) begin
    if (RF_WrEn) begin
      wr_a.push_back(RF_Address);
      wr_d.push_back(RF_WrData);
    end
    if (RF_RdEn) rd_q.push_back(RF_Address);
    if (UART_TX_VLD) tx_q.push_back(UART_TX_DATA);
    if (CMD_ERR) err_cnt++;
    if (UART_TX_VLD && FIFO_FULL) viol++;
    if (ALU_EN && !CLKG_EN) viol++;
    if (ALU_EN) begin
      en_cyc++;
      fun_log = ALU_FUN;
    end
  end

  task automatic clear_logs();
    wr_a.delete();
    wr_d.delete();
    rd_q.delete();
    tx_q.delete();
    err_cnt = 0;
    viol    = 0;
    en_cyc  = 0;
    fun_log = 'x;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge CLK);
    #1;
    UART_RX_DATA = b;
    UART_RX_VLD  = 1'b1;
    @(posedge CLK);
    #1;
    UART_RX_VLD  = 1'b0;
  endtask

  task automatic wait_tx(input int n, input int budget);
    for (int i = 0; i < budget && tx_q.size() < n; i++)
      @(negedge CLK);
    repeat (4) @(negedge CLK);
  endtask

  task automatic test_reset();
    RST          = 1'b0;
    UART_RX_DATA = '0;
    UART_RX_VLD  = 1'b0;
    FIFO_FULL    = 1'b0;
    alu_val      = '0;
    repeat (3) @(negedge CLK);
    total++;
    if ({RF_WrEn, RF_RdEn, ALU_EN, CLKG_EN, CLKDIV_EN,
         UART_TX_VLD, CMD_ERR} !== 7'b0) begin
      bad++;
      $display("FAIL reset_strobes: got %b want 0",
        {RF_WrEn, RF_RdEn, ALU_EN, CLKG_EN, CLKDIV_EN,
         UART_TX_VLD, CMD_ERR});
    end
    total++;
    if ({RF_Address, RF_WrData, ALU_FUN, UART_TX_DATA}
        !== 24'h0) begin
      bad++;
      $display("FAIL reset_buses: got %h want 0",
        {RF_Address, RF_WrData, ALU_FUN, UART_TX_DATA});
    end
    @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK);
    #1;
    total++;
    if (CLKDIV_EN !== 1'b1) begin
      bad++;
      $display("FAIL clkdiv_en: got %b want 1", CLKDIV_EN);
    end
  endtask

  task automatic test_write();
    clear_logs();
    send_byte(8'hAA);
    send_byte(8'h05);
    send_byte(8'h3C);
    repeat (5) @(negedge CLK);
    total++;
    if (wr_a.size() != 1 || wr_a[0] !== 4'h5 ||
        wr_d[0] !== 8'h3C) begin
      bad++;
      $display("FAIL write: n=%0d a=%h d=%h want 1 5 3c",
        wr_a.size(), wr_a[0], wr_d[0]);
    end
    total++;
    if (tx_q.size() != 0) begin
      bad++;
      $display("FAIL write_no_tx: got %0d want 0", tx_q.size());
    end
  endtask

  task automatic test_read();
    clear_logs();
    send_byte(8'hBB);
    send_byte(8'h05);
    wait_tx(1, 40);
    total++;
    if (tx_q.size() != 1 || tx_q[0] !== 8'h3C) begin
      bad++;
      $display("FAIL read_tx: n=%0d d=%h want 1 3c",
        tx_q.size(), tx_q[0]);
    end
    total++;
    if (rd_q.size() != 1 || rd_q[0] !== 4'h5) begin
      bad++;
      $display("FAIL read_addr: n=%0d a=%h want 1 5",
        rd_q.size(), rd_q[0]);
    end
  endtask

  task automatic test_alu_ops();
    clear_logs();
    alu_val = 16'h0046;
    send_byte(8'hCC);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h00);
    wait_tx(2, 40);
    total++;
    if (wr_a.size() != 2 ||
        {wr_a[0], wr_d[0], wr_a[1], wr_d[1]} !== 24'h012134) begin
      bad++;
      $display("FAIL alu_opnd_wr: n=%0d got %h want 012134",
        wr_a.size(), {wr_a[0], wr_d[0], wr_a[1], wr_d[1]});
    end
    total++;
    if (tx_q.size() != 2 || {tx_q[0], tx_q[1]} !== 16'h4600) begin
      bad++;
      $display("FAIL alu_tx: n=%0d got %h want 4600",
        tx_q.size(), {tx_q[0], tx_q[1]});
    end
    total++;
    if (fun_log !== 4'h0 || en_cyc != 3 || viol != 0) begin
      bad++;
      $display("FAIL alu_en: fun=%h cyc=%0d v=%0d want 0 3 0",
        fun_log, en_cyc, viol);
    end
    total++;
    if (CLKG_EN !== 1'b0 || ALU_EN !== 1'b0) begin
      bad++;
      $display("FAIL alu_gate_off: got %b%b want 00",
        CLKG_EN, ALU_EN);
    end
  endtask

  task automatic test_alu_fun();
    clear_logs();
    alu_val = 16'h1234;
    send_byte(8'hDD);
    send_byte(8'hF3);
    wait_tx(2, 40);
    total++;
    if (tx_q.size() != 2 || {tx_q[0], tx_q[1]} !== 16'h3412) begin
      bad++;
      $display("FAIL alu_fun_tx: n=%0d got %h want 3412",
        tx_q.size(), {tx_q[0], tx_q[1]});
    end
    total++;
    if (fun_log !== 4'h3 || wr_a.size() != 0) begin
      bad++;
      $display("FAIL alu_fun: fun=%h wr=%0d want 3 0",
        fun_log, wr_a.size());
    end
  endtask

  task automatic test_burst_read();
    int n;
    clear_logs();
    send_byte(8'hEF);
    send_byte(8'h0E);
    send_byte(8'h03);
    for (n = 0; n < 40 && tx_q.size() < 1; n++)
      @(negedge CLK);
    @(posedge CLK);
    #1 FIFO_FULL = 1'b1;
    repeat (5) @(posedge CLK);
    #1 FIFO_FULL = 1'b0;
    wait_tx(3, 60);
    total++;
    if (rd_q.size() != 3 ||
        {rd_q[0], rd_q[1], rd_q[2]} !== 12'hEF0) begin
      bad++;
      $display("FAIL brd_addr: n=%0d got %h want ef0",
        rd_q.size(), {rd_q[0], rd_q[1], rd_q[2]});
    end
    total++;
    if (tx_q.size() != 3 ||
        {tx_q[0], tx_q[1], tx_q[2]} !== 24'h1E1F12) begin
      bad++;
      $display("FAIL brd_tx: n=%0d got %h want 1e1f12",
        tx_q.size(), {tx_q[0], tx_q[1], tx_q[2]});
    end
    total++;
    if (viol != 0) begin
      bad++;
      $display("FAIL brd_full: got %0d writes while full want 0",
        viol);
    end
  endtask

  task automatic test_burst_zero_err();
    clear_logs();
    send_byte(8'hEE);
    send_byte(8'h02);
    send_byte(8'h00);
    repeat (5) @(negedge CLK);
    total++;
    if (wr_a.size() + rd_q.size() + err_cnt != 0) begin
      bad++;
      $display("FAIL bwr_zero: wr=%0d rd=%0d err=%0d want 0",
        wr_a.size(), rd_q.size(), err_cnt);
    end
    send_byte(8'h55);
    repeat (4) @(negedge CLK);
    total++;
    if (err_cnt != 1) begin
      bad++;
      $display("FAIL bad_opcode: err cycles %0d want 1", err_cnt);
    end
    clear_logs();
    send_byte(8'hAA);
    send_byte(8'h07);
    send_byte(8'h99);
    repeat (5) @(negedge CLK);
    total++;
    if (wr_a.size() != 1 || {wr_a[0], wr_d[0]} !== 12'h799) begin
      bad++;
      $display("FAIL after_err: n=%0d got %h want 799",
        wr_a.size(), {wr_a[0], wr_d[0]});
    end
  endtask

  task automatic test_burst_wrap();
    clear_logs();
    send_byte(8'hEE);
    send_byte(8'h0F);
    send_byte(8'h02);
    send_byte(8'hA1);
    send_byte(8'hA2);
    repeat (5) @(negedge CLK);
    total++;
    if (wr_a.size() != 2 ||
        {wr_a[0], wr_d[0], wr_a[1], wr_d[1]} !== 24'hFA10A2) begin
      bad++;
      $display("FAIL bwr_wrap: n=%0d got %h want fa10a2",
        wr_a.size(), {wr_a[0], wr_d[0], wr_a[1], wr_d[1]});
    end
  endtask

  task automatic test_reset_mid();
    int n;
    clear_logs();
    send_byte(8'hEE);
    send_byte(8'h03);
    send_byte(8'h04);
    send_byte(8'hB1);
    for (n = 0; n < 10 && !RF_WrEn; n++)
      @(negedge CLK);
    total++;
    if (RF_WrEn !== 1'b1) begin
      bad++;
      $display("FAIL mid_wr_seen: got %b want 1", RF_WrEn);
    end
    RST = 1'b0;
    #1;
    total++;
    if ({RF_WrEn, RF_RdEn, ALU_EN, CLKG_EN, CLKDIV_EN,
         UART_TX_VLD, CMD_ERR} !== 7'b0) begin
      bad++;
      $display("FAIL mid_reset: got %b want 0",
        {RF_WrEn, RF_RdEn, ALU_EN, CLKG_EN, CLKDIV_EN,
         UART_TX_VLD, CMD_ERR});
    end
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
    clear_logs();
    send_byte(8'hAA);
    send_byte(8'h01);
    send_byte(8'hFF);
    repeat (5) @(negedge CLK);
    total++;
    if (wr_a.size() != 1 || {wr_a[0], wr_d[0]} !== 12'h1FF) begin
      bad++;
      $display("FAIL post_reset_wr: n=%0d got %h want 1ff",
        wr_a.size(), {wr_a[0], wr_d[0]});
    end
  endtask

`ifdef CMD_TIMEOUT_EN
  task automatic test_timeout();
    clear_logs();
    send_byte(8'hAA);
    send_byte(8'h01);
    repeat (1000) @(negedge CLK);
    total++;
    if (err_cnt != 0) begin
      bad++;
      $display("FAIL tmo_early: err %0d want 0", err_cnt);
    end
    repeat (60) @(negedge CLK);
    total++;
    if (err_cnt != 1 || wr_a.size() != 0) begin
      bad++;
      $display("FAIL tmo: err=%0d wr=%0d want 1 0",
        err_cnt, wr_a.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_alu_ops();
    test_alu_fun();
    test_burst_read();
    test_burst_zero_err();
    test_burst_wrap();
    test_reset_mid();
`ifdef CMD_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sys_ctrl_burst.md
Name: sys_ctrl_burst

Overview:
Parametrised successor of the system controller, sitting between the RX data synchroniser, register file, ALU/clock gate and TX async FIFO in the REF_CLK domain. Decodes UART command frames into RF reads/writes and ALU operations, and serialises multi-byte responses into the TX FIFO with full-flag back-pressure. Adds burst RF read/write, generic ALU result width, and an error pulse for unknown opcodes.

Parameters:
DATA_WIDTH, 8, UART byte, RF word and operand width
RF_ADDR, 4, RF address width; addresses wrap modulo 2**RF_ADDR
ALU_FUN_W, 4, ALU function code width
ALU_OUT_W, 16, ALU result width; OUT_BYTES = ceil(ALU_OUT_W/DATA_WIDTH)
TIMEOUT_CYC, 1024, inter-byte timeout in CLK cycles (only with the optional feature)

Ports:
CLK  in  1  REF_CLK domain clock
RST  in  1  asynchronous active-low reset
UART_RX_DATA  in  DATA_WIDTH  synchronised RX byte
UART_RX_VLD  in  1  one-cycle pulse, byte valid
RF_RdData  in  DATA_WIDTH  RF read data
RF_RdData_VLD  in  1  RF read data valid
ALU_OUT  in  ALU_OUT_W  ALU result
ALU_OUT_VLD  in  1  ALU result valid
FIFO_FULL  in  1  TX FIFO full
RF_WrEn, RF_RdEn  out  1  RF strobes
RF_Address  out  RF_ADDR  RF address
RF_WrData  out  DATA_WIDTH  RF write data
ALU_EN  out  1  ALU enable
ALU_FUN  out  ALU_FUN_W  ALU function
CLKG_EN  out  1  ALU clock-gate enable
CLKDIV_EN  out  1  UART clock divider enable
UART_TX_DATA  out  DATA_WIDTH  byte to TX FIFO
UART_TX_VLD  out  1  one-cycle FIFO write strobe
CMD_ERR  out  1  one-cycle pulse: unknown opcode or timeout abort

Behaviour:
- Reset: all outputs 0 except CLKDIV_EN (0 in reset, registered 1 from first clock after release); FSM to IDLE.
- Opcodes (first byte in IDLE): 0xAA write {addr,data}; 0xBB read {addr}; 0xCC ALU with operands {A,B,fun}; 0xDD ALU {fun}; 0xEE burst write {addr,cnt,cnt data bytes}; 0xEF burst read {addr,cnt}. Other byte -> CMD_ERR pulse, stay IDLE.
- Address bytes use the low RF_ADDR bits; fun bytes use the low ALU_FUN_W bits.
- States: IDLE, GET_ADDR, GET_CNT, GET_DATA, RF_WR, RF_RD, RD_WAIT, GET_A, GET_B, GET_FUN, ALU_RUN, ALU_WAIT, TX_SEND.
- RF write: RF_WrEn high exactly one cycle, the cycle after the data byte's VLD. 0xCC writes A to addr 0 and B to addr 1 this way.
- RF read: RF_RdEn high one cycle. Hold in RD_WAIT until RF_RdData_VLD, capture, go to TX_SEND.
- ALU: CLKG_EN rises the cycle after the fun byte; ALU_EN + ALU_FUN asserted the next cycle and held until ALU_OUT_VLD. Capture ALU_OUT; CLKG_EN and ALU_EN drop the following cycle.
- TX_SEND: one byte per cycle with UART_TX_VLD=1 only while FIFO_FULL=0; FULL stalls with data held. ALU result is sent LSB byte first, OUT_BYTES bytes, MSB byte zero-padded.
- Burst: cnt=0 -> return to IDLE, no RF access, no error. Address increments after each access and wraps 2**RF_ADDR-1 -> 0.
- Burst read interleaves RF_RD -> RD_WAIT -> TX_SEND per word.
- UART_RX_VLD outside a GET_* state is dropped.

Optional Feature:
CMD_TIMEOUT_EN. Defined: a counter resets on each accepted byte; in any GET_* state, TIMEOUT_CYC cycles without UART_RX_VLD -> CMD_ERR pulse, return to IDLE, partial burst writes already committed stay. Undefined: no counter; the FSM waits indefinitely.

Decomposition:
- Package sys_ctrl_pkg: opcode constants, state enum, OUT_BYTES function.
- One sub-module, tx_byte_ser: byte-serialiser with FIFO_FULL stall, loaded with a word of up to OUT_BYTES bytes.

Test Plan:
- AA,05,3C -> one RF_WrEn cycle, addr 5, data 0x3C; no TX.
- BB,05 with RF returning 0x3C after 2 cycles -> exactly one UART_TX_VLD with 0x3C.
- CC,12,34,00 with ALU_OUT=0x0046 -> writes addr0=0x12, addr1=0x34; ALU_FUN=0; TX 0x46 then 0x00; CLKG_EN low afterwards.
- EF,0E,03 (RF_ADDR=4) with FIFO_FULL held 5 cycles mid-burst -> reads addresses 14,15,0 in order, 3 TX bytes, no drop or duplicate.
- EE,02,00 -> no RF activity, back to IDLE; then 0x55 -> CMD_ERR pulse.
- Reset asserted mid-burst -> all strobes 0 immediately; after release, AA,01,FF executes normally. With CMD_TIMEOUT_EN, AA,01 then silence -> CMD_ERR after TIMEOUT_CYC cycles.
